// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned CNT_W = 4;

  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_ctrl_stall_timer.sv
// Loadable down-counter that times the remaining cycles of a multi-cycle stall.
module stall_timer
  import hazard_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadValue,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // load wins over dec; the count never wraps below zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= loadValue;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush controller for load-use, multi-cycle multiply and taken-branch hazards.
// Optional HAZARD_STALL_CNT_EN adds a saturating stallCount output.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LATENCY       = 4,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDtoEXmemRead,
  input  logic [REG_W-1:0] IDtoEXRt,
  input  logic [REG_W-1:0] Rs,
  input  logic [REG_W-1:0] Rt,
  input  logic             mulStart,
  input  logic             branchTaken,
  output logic             pcWrite,
  output logic             IFtoIDwrite,
  output logic             IDtoEXflush,
  output logic             IFtoIDflush,
  output logic             mulBusy,
  output logic             mulDone
`ifdef HAZARD_STALL_CNT_EN
  ,
  output logic [31:0]      stallCount
`endif
);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 2);
  localparam logic [CNT_W-1:0] LD_LOAD  = CNT_W'((LOAD_STALL_CYCLES > 1) ? LOAD_STALL_CYCLES - 2 : 0);

  state_t           state, stateNext;
  logic             loadHazard;
  logic             tLoad, tDec, tZero;
  logic [CNT_W-1:0] tLoadValue;

  assign loadHazard = IDtoEXmemRead && (IDtoEXRt != REG_ZERO) &&
                      ((IDtoEXRt == Rs) || (IDtoEXRt == Rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= stateNext;
  end

  stall_timer uTimer (
    .clk       (clk),
    .rst       (rst),
    .load      (tLoad),
    .loadValue (tLoadValue),
    .dec       (tDec),
    .zero      (tZero)
  );

  // Outputs are Mealy in RUN; rst gates them so an asserted reset looks idle at once
  always_comb begin
    stateNext   = state;
    pcWrite     = 1'b1;
    IFtoIDwrite = 1'b1;
    IDtoEXflush = 1'b0;
    IFtoIDflush = 1'b0;
    mulBusy     = 1'b0;
    mulDone     = 1'b0;
    tLoad       = 1'b0;
    tLoadValue  = '0;
    tDec        = 1'b0;
    if (!rst) begin
      case (state)
        RUN: begin
          if (mulStart) begin
            pcWrite     = 1'b0;
            IFtoIDwrite = 1'b0;
            IDtoEXflush = 1'b1;
            mulBusy     = 1'b1;
            tLoad       = 1'b1;
            tLoadValue  = MUL_LOAD;
            stateNext   = MUL_WAIT;
          end else if (branchTaken) begin
            IFtoIDflush = 1'b1;
          end else if (loadHazard) begin
            pcWrite     = 1'b0;
            IFtoIDwrite = 1'b0;
            IDtoEXflush = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
              tLoad      = 1'b1;
              tLoadValue = LD_LOAD;
              stateNext  = LD_STALL;
            end
          end
        end
        LD_STALL: begin
          pcWrite     = 1'b0;
          IFtoIDwrite = 1'b0;
          IDtoEXflush = 1'b1;
          if (tZero) stateNext = RUN;
          else       tDec      = 1'b1;
        end
        MUL_WAIT: begin
          pcWrite     = 1'b0;
          IFtoIDwrite = 1'b0;
          IDtoEXflush = 1'b1;
          mulBusy     = 1'b1;
          if (tZero) begin
            mulDone   = 1'b1;
            stateNext = RUN;
          end else begin
            tDec = 1'b1;
          end
        end
        default: stateNext = RUN;
      endcase
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCount <= '0;
    end else if (!pcWrite && (stallCount != '1)) begin
      stallCount <= stallCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (LOAD_STALL_CYCLES 1 and 3 instances).
module tb_hazard_ctrl;
  import hazard_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             memRead, mulStart, branchTaken;
  logic [REG_W-1:0] exRt, rs, rt;

  logic pcWrite, ifidWrite, idexFlush, ifidFlush, mulBusy, mulDone;
  logic pcWrite3, ifidWrite3, idexFlush3, ifidFlush3, mulBusy3, mulDone3;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stallCount, stallCount3;
`endif

  logic [5:0] obs, obs3;
  assign obs  = {pcWrite, ifidWrite, idexFlush, ifidFlush, mulBusy, mulDone};
  assign obs3 = {pcWrite3, ifidWrite3, idexFlush3, ifidFlush3, mulBusy3, mulDone3};

  int unsigned nChecks = 0;
  int unsigned nFail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_LATENCY(4), .LOAD_STALL_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .IDtoEXmemRead(memRead), .IDtoEXRt(exRt), .Rs(rs), .Rt(rt),
    .mulStart(mulStart), .branchTaken(branchTaken), .pcWrite(pcWrite),
    .IFtoIDwrite(ifidWrite), .IDtoEXflush(idexFlush), .IFtoIDflush(ifidFlush),
    .mulBusy(mulBusy), .mulDone(mulDone)
`ifdef HAZARD_STALL_CNT_EN
    , .stallCount(stallCount)
`endif
  );

  hazard_ctrl #(.MUL_LATENCY(4), .LOAD_STALL_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .IDtoEXmemRead(memRead), .IDtoEXRt(exRt), .Rs(rs), .Rt(rt),
    .mulStart(mulStart), .branchTaken(branchTaken), .pcWrite(pcWrite3),
    .IFtoIDwrite(ifidWrite3), .IDtoEXflush(idexFlush3), .IFtoIDflush(ifidFlush3),
    .mulBusy(mulBusy3), .mulDone(mulDone3)
`ifdef HAZARD_STALL_CNT_EN
    , .stallCount(stallCount3)
`endif
  );

  // Expected vectors are {pcWrite, IFtoIDwrite, IDtoEXflush, IFtoIDflush, mulBusy, mulDone}
  localparam logic [5:0] IDLE  = 6'b110000;
  localparam logic [5:0] LDSTL = 6'b001000;
  localparam logic [5:0] MULST = 6'b001010;
  localparam logic [5:0] MULDN = 6'b001011;
  localparam logic [5:0] BRFL  = 6'b110100;

  typedef struct {
    string            name;
    logic             memRead;
    logic [REG_W-1:0] exRt, rs, rt;
    logic             br;
    logic [5:0]       exp;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [5:0] got, input logic [5:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic drive(input logic mr, input logic [REG_W-1:0] xr, input logic [REG_W-1:0] s,
                       input logic [REG_W-1:0] t, input logic m, input logic b);
    memRead = mr; exRt = xr; rs = s; rt = t; mulStart = m; branchTaken = b;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    nextCycle();
    rst = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextCycle();
    rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"idle",          1'b0, 5'd0, 5'd0, 5'd0, 1'b0, IDLE};
    vecs[1] = '{"loadUseRs",     1'b1, 5'd5, 5'd5, 5'd0, 1'b0, LDSTL};
    vecs[2] = '{"afterOneStall", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, IDLE};
    vecs[3] = '{"loadUseRt",     1'b1, 5'd7, 5'd3, 5'd7, 1'b0, LDSTL};
    vecs[4] = '{"zeroReg",       1'b1, 5'd0, 5'd0, 5'd0, 1'b0, IDLE};
    vecs[5] = '{"noMemRead",     1'b0, 5'd5, 5'd5, 5'd5, 1'b0, IDLE};
    vecs[6] = '{"noMatch",       1'b1, 5'd9, 5'd1, 5'd2, 1'b0, IDLE};
    vecs[7] = '{"branchOnly",    1'b0, 5'd0, 5'd0, 5'd0, 1'b1, BRFL};
    vecs[8] = '{"branchOverLd",  1'b1, 5'd5, 5'd5, 5'd0, 1'b1, BRFL};

    // Reset with events on the inputs: outputs must still look idle
    rst = 1'b1;
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
    #3;
    check("resetOutputs", obs, IDLE);
    nextCycle();
    rst = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      nextCycle();
      drive(vecs[i].memRead, vecs[i].exRt, vecs[i].rs, vecs[i].rt, 1'b0, vecs[i].br);
      #3;
      check(vecs[i].name, obs, vecs[i].exp);
    end

    // Multiply; hazards offered during MUL_WAIT must be ignored
    doReset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    #3; check("mulCyc1", obs, MULST);
    nextCycle(); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
    #3; check("mulCyc2", obs, MULST);
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3; check("mulCyc3", obs, MULST);
    nextCycle();
    #3; check("mulCyc4Done", obs, MULDN);
    nextCycle();
    #3; check("mulBackToRun", obs, IDLE);

    // mulStart with branchTaken and a load hazard: multiply wins, no IF/ID flush
    nextCycle(); drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b1);
    #3; check("mulOverBranch", obs, MULST);
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3; check("mulOverBranchWait", obs, MULST);
    nextCycle(); nextCycle();
    #3; check("mulOverBranchDone", obs, MULDN);

    // Load-use stall of three cycles on the LOAD_STALL_CYCLES=3 instance
    doReset();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    #3; check("ld3Cyc1", obs3, LDSTL);
    nextCycle();
    #3; check("ld3Cyc2", obs3, LDSTL);
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    #3; check("ld3Cyc3", obs3, LDSTL);
    nextCycle();
    #3; check("ld3BackToRun", obs3, IDLE);

    // Reset asserted in the second MUL_WAIT cycle aborts the multiply
    doReset();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextCycle();
    #2; check("midMulBusy", obs, MULST);
    rst = 1'b1;
    #1; check("midMulAsyncReset", obs, IDLE);
    nextCycle();
    #3; check("midMulHeldReset", obs, IDLE);
    rst = 1'b0;
    nextCycle();
    #3; check("midMulNoDone", obs, IDLE);
    // First edge after reset evaluates in RUN, so a fresh multiply starts cleanly
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    #1; check("postResetMul", obs, MULST);
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextCycle(); nextCycle();
    #3; check("postResetMulDone", obs, MULDN);

`ifdef HAZARD_STALL_CNT_EN
    doReset();
    #3; check32("stallCountReset", stallCount, 32'd0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextCycle(); nextCycle(); nextCycle();
    drive(1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0);
    nextCycle(); drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    nextCycle();
    #3; check32("stallCountMulPlusLoad", stallCount, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete, required finish before 50000");
    $fatal(1);
  end

endmodule
